// File: rtl/mem_pkg.sv
// Shared encodings for the handshake main memory: access sizes, FSM states, size helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package mem_pkg;

  // Access size as driven on TYPE by the control unit
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  // Handshake controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int CNT_W = 4;

  // Number of bytes touched by an access; the reserved code is rejected
  // elsewhere, so its value here only needs to be harmless.
  function automatic logic [2:0] size_bytes(input size_t sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load alignment/extension: picks byte, halfword or word from 4 big-endian bytes and extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [7:0]  b0,   // byte at A (most significant)
  input  logic [7:0]  b1,   // byte at A+1
  input  logic [7:0]  b2,   // byte at A+2
  input  logic [7:0]  b3,   // byte at A+3
  input  logic [1:0]  typ,
  input  logic        sgn,
  output logic [31:0] ext
);

  // Select the addressed field and fill the upper bits with zero or its sign bit
  always_comb begin
    ext = {b0, b1, b2, b3};
    case (size_t'(typ))
      SZ_BYTE: ext = {{24{sgn & b0[7]}}, b0};
      SZ_HALF: ext = {{16{sgn & b0[7]}}, b0, b1};
      default: ext = {b0, b1, b2, b3};
    endcase
  end

endmodule

// File: rtl/mem_handshake_ram.sv
// Byte-addressable big-endian RAM behind a MOV/MOC four-phase handshake with programmable wait states.
// Latency: MOC rises LATENCY+1 edges after MOV is sampled in IDLE; rejected requests complete in one edge.
// Backpressure: MOC/ERR/DOUT hold in DONE until MOV drops; a new request needs one MOV-low cycle first.
module mem_handshake_ram
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        TYPE,
  input  logic              SGN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              MOC,
  output logic              ERR
);

  localparam int              AW  = $clog2(DEPTH);
  localparam int              AXW = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

  // Storage; deliberately not touched by CLR
  logic [7:0] mem [0:DEPTH-1];

  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;

  // Request captured on the accepting edge
  logic              req_rw;
  logic              req_sgn;
  size_t             req_type;
  logic [AW-1:0]     req_addr;
  logic [DATA_W-1:0] req_din;
  logic              err_q;
  logic [DATA_W-1:0] dout_q;

  // Live request check and access control
  logic           req_err;
  logic [AXW-1:0] last_byte;
  logic           finish;
  logic           do_write;
  logic [AW-1:0]  a1, a2, a3;
  logic [31:0]    ext;

  // Validate the incoming request: reserved size, misalignment, or any byte past the array end
  always_comb begin
    req_err   = 1'b0;
    last_byte = {1'b0, ADDR} + AXW'(size_bytes(size_t'(TYPE))) - AXW'(1);
    case (size_t'(TYPE))
      SZ_RSVD: req_err = 1'b1;
      SZ_HALF: if (ADDR[0]) req_err = 1'b1;
      SZ_WORD: if (ADDR[1:0] != 2'b00) req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    // Upper address bits set also land here since the sum then exceeds DEPTH
    if (last_byte >= AXW'(DEPTH)) req_err = 1'b1;
  end

  // Next-state logic of the handshake controller
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (MOV) state_nxt = req_err ? ST_DONE : ST_BUSY;
      ST_BUSY: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE: if (!MOV) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset mid-access drops straight back to IDLE
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  assign finish   = (state == ST_BUSY) && (cnt == '0);
  assign do_write = finish && !req_rw;

  // Neighbouring byte addresses of the latched access (wrap is harmless: only in-range bytes are used)
  assign a1 = req_addr + AW'(1);
  assign a2 = req_addr + AW'(2);
  assign a3 = req_addr + AW'(3);

  mem_load_extend u_extend (
    .b0  (mem[req_addr]),
    .b1  (mem[a1]),
    .b2  (mem[a2]),
    .b3  (mem[a3]),
    .typ (req_type),
    .sgn (req_sgn),
    .ext (ext)
  );

  // Request capture, wait counter, error flag and registered read data
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt      <= '0;
      err_q    <= 1'b0;
      dout_q   <= '0;
      req_rw   <= 1'b0;
      req_sgn  <= 1'b0;
      req_type <= SZ_BYTE;
      req_addr <= '0;
      req_din  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MOV) begin
            req_rw   <= RW;
            req_sgn  <= SGN;
            req_type <= size_t'(TYPE);
            req_addr <= ADDR[AW-1:0];
            req_din  <= DIN;
            err_q    <= req_err;
            cnt      <= req_err ? '0 : LAT;
          end
        end
        ST_BUSY: begin
          if (cnt != '0)  cnt    <= cnt - CNT_W'(1);
          else if (req_rw) dout_q <= DATA_W'(ext);
        end
        ST_DONE: begin
          if (!MOV) err_q <= 1'b0;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Array write on the completing edge; only the addressed bytes change
  always_ff @(posedge CLK) begin
    if (do_write) begin
      case (req_type)
        SZ_BYTE: mem[req_addr] <= req_din[7:0];
        SZ_HALF: begin
          mem[req_addr] <= req_din[15:8];
          mem[a1]       <= req_din[7:0];
        end
        default: begin
          mem[req_addr] <= req_din[31:24];
          mem[a1]       <= req_din[23:16];
          mem[a2]       <= req_din[15:8];
          mem[a3]       <= req_din[7:0];
        end
      endcase
    end
  end

  assign MOC  = (state == ST_DONE);
  assign ERR  = (state == ST_DONE) && err_q;
  assign DOUT = dout_q;

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Directed bench for mem_handshake_ram: LATENCY=2 instance plus a LATENCY=0 instance.
// Inputs driven on the falling edge, outputs sampled #1 after the rising edge.
// Each scenario task carries its own hand-computed expectations.
module tb_mem_handshake_ram;
  import mem_pkg::*;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        MOV, RW, SGN;
  logic [1:0]  TYPE;
  logic [31:0] ADDR, DIN, DOUT;
  logic        MOC, ERR;

  logic        MOV2, RW2, SGN2;
  logic [1:0]  TYPE2;
  logic [31:0] ADDR2, DIN2, DOUT2;
  logic        MOC2, ERR2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  mem_handshake_ram #(.DEPTH(256), .ADDR_W(32), .DATA_W(32), .LATENCY(2)) dut (
    .CLK(CLK), .CLR(CLR), .MOV(MOV), .RW(RW), .TYPE(TYPE), .SGN(SGN),
    .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .MOC(MOC), .ERR(ERR)
  );

  mem_handshake_ram #(.DEPTH(256), .ADDR_W(32), .DATA_W(32), .LATENCY(0)) dut0 (
    .CLK(CLK), .CLR(CLR), .MOV(MOV2), .RW(RW2), .TYPE(TYPE2), .SGN(SGN2),
    .ADDR(ADDR2), .DIN(DIN2), .DOUT(DOUT2), .MOC(MOC2), .ERR(ERR2)
  );

  // Drive one request on the main instance and count edges from capture to MOC (99 = timed out)
  task automatic issue(input logic rw, input logic [1:0] ty, input logic sg,
                       input logic [31:0] a, input logic [31:0] d, output int edges);
    @(negedge CLK);
    RW = rw; TYPE = ty; SGN = sg; ADDR = a; DIN = d; MOV = 1'b1;
    @(posedge CLK);
    edges = 0;
    do begin
      @(posedge CLK); #1;
      edges++;
    end while (!MOC && edges < 20);
    if (!MOC) edges = 99;
  endtask

  // Drop MOV and report MOC one edge later
  task automatic release_mov(output logic moc_after);
    @(negedge CLK);
    MOV = 1'b0;
    @(posedge CLK); #1;
    moc_after = MOC;
  endtask

  task automatic test_reset();
    #1 CLR = 1'b1;
    #3;
    n_cmp++; if (MOC !== 1'b0) begin n_fail++; $display("FAIL reset_moc got=%b exp=0", MOC); end
    n_cmp++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", ERR); end
    n_cmp++; if (DOUT !== 32'h0) begin n_fail++; $display("FAIL reset_dout got=%h exp=00000000", DOUT); end
    n_cmp++; if (MOC2 !== 1'b0) begin n_fail++; $display("FAIL reset_moc_lat0 got=%b exp=0", MOC2); end
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  task automatic test_word_read();
    int e; logic m;
    issue(1'b1, 2'b10, 1'b0, 32'd4, 32'h0, e);
    n_cmp++; if (e !== 3) begin n_fail++; $display("FAIL wr_latency got=%0d exp=3", e); end
    n_cmp++; if (DOUT !== 32'h8C010203) begin n_fail++; $display("FAIL wr_dout got=%h exp=8c010203", DOUT); end
    n_cmp++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL wr_err got=%b exp=0", ERR); end
    release_mov(m);
    n_cmp++; if (m !== 1'b0) begin n_fail++; $display("FAIL wr_moc_drop got=%b exp=0", m); end
    n_cmp++; if (DOUT !== 32'h8C010203) begin n_fail++; $display("FAIL wr_dout_hold got=%h exp=8c010203", DOUT); end
  endtask

  task automatic test_extend();
    int e; logic m;
    issue(1'b1, 2'b00, 1'b1, 32'd4, 32'h0, e);
    n_cmp++; if (DOUT !== 32'hFFFFFF8C) begin n_fail++; $display("FAIL byte_sext got=%h exp=ffffff8c", DOUT); end
    release_mov(m);
    issue(1'b1, 2'b00, 1'b0, 32'd4, 32'h0, e);
    n_cmp++; if (DOUT !== 32'h0000008C) begin n_fail++; $display("FAIL byte_zext got=%h exp=0000008c", DOUT); end
    release_mov(m);
    issue(1'b1, 2'b01, 1'b1, 32'd6, 32'h0, e);
    n_cmp++; if (DOUT !== 32'h00000203) begin n_fail++; $display("FAIL half_sext got=%h exp=00000203", DOUT); end
    n_cmp++; if (e !== 3) begin n_fail++; $display("FAIL half_latency got=%0d exp=3", e); end
    release_mov(m);
  endtask

  task automatic test_half_write();
    int e; logic m;
    issue(1'b0, 2'b01, 1'b0, 32'd8, 32'h0000BEEF, e);
    n_cmp++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL hw_err got=%b exp=0", ERR); end
    release_mov(m);
    n_cmp++; if (dut.mem[8] !== 8'hBE) begin n_fail++; $display("FAIL hw_mem8 got=%h exp=be", dut.mem[8]); end
    n_cmp++; if (dut.mem[9] !== 8'hEF) begin n_fail++; $display("FAIL hw_mem9 got=%h exp=ef", dut.mem[9]); end
    n_cmp++; if (dut.mem[10] !== 8'h33) begin n_fail++; $display("FAIL hw_mem10 got=%h exp=33", dut.mem[10]); end
    n_cmp++; if (dut.mem[11] !== 8'h44) begin n_fail++; $display("FAIL hw_mem11 got=%h exp=44", dut.mem[11]); end
    issue(1'b1, 2'b10, 1'b0, 32'd8, 32'h0, e);
    n_cmp++; if (DOUT !== 32'hBEEF3344) begin n_fail++; $display("FAIL hw_readback got=%h exp=beef3344", DOUT); end
    release_mov(m);
  endtask

  task automatic test_errors();
    int e; logic m;
    issue(1'b1, 2'b10, 1'b0, 32'd6, 32'h0, e);
    n_cmp++; if (e !== 1) begin n_fail++; $display("FAIL mis_latency got=%0d exp=1", e); end
    n_cmp++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL mis_err got=%b exp=1", ERR); end
    n_cmp++; if (DOUT !== 32'hBEEF3344) begin n_fail++; $display("FAIL mis_dout got=%h exp=beef3344", DOUT); end
    release_mov(m);
    n_cmp++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL mis_err_clear got=%b exp=0", ERR); end
    issue(1'b0, 2'b11, 1'b0, 32'd0, 32'h55555555, e);
    n_cmp++; if (e !== 1) begin n_fail++; $display("FAIL rsvd_latency got=%0d exp=1", e); end
    n_cmp++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL rsvd_err got=%b exp=1", ERR); end
    release_mov(m);
    n_cmp++; if (dut.mem[0] !== 8'hA0) begin n_fail++; $display("FAIL rsvd_mem0 got=%h exp=a0", dut.mem[0]); end
    issue(1'b0, 2'b10, 1'b0, 32'd252, 32'h66666666, e);
    n_cmp++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL top_word_err got=%b exp=0", ERR); end
    release_mov(m);
    issue(1'b1, 2'b10, 1'b0, 32'd254, 32'h0, e);
    n_cmp++; if (e !== 1) begin n_fail++; $display("FAIL range_latency got=%0d exp=1", e); end
    n_cmp++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL range_err got=%b exp=1", ERR); end
    n_cmp++; if (DOUT !== 32'hBEEF3344) begin n_fail++; $display("FAIL range_dout got=%h exp=beef3344", DOUT); end
    release_mov(m);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0100, 32'h0, e);
    n_cmp++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL high_addr_err got=%b exp=1", ERR); end
    release_mov(m);
  endtask

  task automatic test_reset_mid_busy();
    int e; logic m;
    @(negedge CLK);
    RW = 1'b0; TYPE = 2'b10; SGN = 1'b0; ADDR = 32'd0; DIN = 32'hDEADBEEF; MOV = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #2 CLR = 1'b1;
    #1;
    n_cmp++; if (MOC !== 1'b0) begin n_fail++; $display("FAIL abort_moc got=%b exp=0", MOC); end
    n_cmp++; if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL abort_state got=%0d exp=%0d", dut.state, ST_IDLE); end
    n_cmp++; if (DOUT !== 32'h0) begin n_fail++; $display("FAIL abort_dout got=%h exp=00000000", DOUT); end
    MOV = 1'b0;
    @(negedge CLK);
    CLR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if ({dut.mem[0], dut.mem[1], dut.mem[2], dut.mem[3]} !== 32'hA0A1A2A3)
      begin n_fail++; $display("FAIL abort_mem got=%h exp=a0a1a2a3", {dut.mem[0], dut.mem[1], dut.mem[2], dut.mem[3]}); end
    issue(1'b1, 2'b10, 1'b0, 32'd0, 32'h0, e);
    n_cmp++; if (e !== 3) begin n_fail++; $display("FAIL after_abort_latency got=%0d exp=3", e); end
    n_cmp++; if (DOUT !== 32'hA0A1A2A3) begin n_fail++; $display("FAIL after_abort_dout got=%h exp=a0a1a2a3", DOUT); end
    release_mov(m);
  endtask

  task automatic test_back_to_back();
    int e;
    @(negedge CLK);
    RW2 = 1'b1; TYPE2 = 2'b10; SGN2 = 1'b0; ADDR2 = 32'd16; MOV2 = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1;
    n_cmp++; if (MOC2 !== 1'b1) begin n_fail++; $display("FAIL lat0_moc got=%b exp=1", MOC2); end
    n_cmp++; if (DOUT2 !== 32'h01020304) begin n_fail++; $display("FAIL lat0_dout got=%h exp=01020304", DOUT2); end
    // Change the source byte while MOV stays high; a repeated access would expose it
    @(negedge CLK);
    dut0.mem[16] = 8'h77;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (MOC2 !== 1'b1) begin n_fail++; $display("FAIL lat0_hold_moc got=%b exp=1", MOC2); end
    n_cmp++; if (DOUT2 !== 32'h01020304) begin n_fail++; $display("FAIL lat0_no_reaccess got=%h exp=01020304", DOUT2); end
    @(negedge CLK);
    MOV2 = 1'b0;
    @(posedge CLK); #1;
    n_cmp++; if (MOC2 !== 1'b0) begin n_fail++; $display("FAIL lat0_drop got=%b exp=0", MOC2); end
    @(negedge CLK);
    MOV2 = 1'b1;
    @(posedge CLK);
    e = 0;
    do begin
      @(posedge CLK); #1;
      e++;
    end while (!MOC2 && e < 20);
    n_cmp++; if (e !== 1) begin n_fail++; $display("FAIL lat0_second_latency got=%0d exp=1", e); end
    n_cmp++; if (DOUT2 !== 32'h77020304) begin n_fail++; $display("FAIL lat0_second_dout got=%h exp=77020304", DOUT2); end
    @(negedge CLK);
    MOV2 = 1'b0;
  endtask

  initial begin
    CLR = 1'b0;
    MOV = 1'b0; RW = 1'b0; TYPE = 2'b00; SGN = 1'b0; ADDR = '0; DIN = '0;
    MOV2 = 1'b0; RW2 = 1'b0; TYPE2 = 2'b00; SGN2 = 1'b0; ADDR2 = '0; DIN2 = '0;
    dut.mem[0] = 8'hA0; dut.mem[1] = 8'hA1; dut.mem[2] = 8'hA2; dut.mem[3] = 8'hA3;
    dut.mem[4] = 8'h8C; dut.mem[5] = 8'h01; dut.mem[6] = 8'h02; dut.mem[7] = 8'h03;
    dut.mem[8] = 8'h11; dut.mem[9] = 8'h22; dut.mem[10] = 8'h33; dut.mem[11] = 8'h44;
    dut0.mem[16] = 8'h01; dut0.mem[17] = 8'h02; dut0.mem[18] = 8'h03; dut0.mem[19] = 8'h04;

    test_reset();
    test_word_read();
    test_extend();
    test_half_write();
    test_errors();
    test_reset_mid_busy();
    test_back_to_back();

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_handshake_ram.md
Name: mem_handshake_ram

Overview:
- Parametrised byte-addressable main memory with a MOV/MOC four-phase handshake and a programmable wait-state latency.
- Successor to the fixed 256x8 RAM: width/depth parameters, sign-extending loads, misalignment and range error reporting, and exact cycle-level MOC timing.
- Sits between MAR/MDR and the control unit. The control unit drives MOV/RW/TYPE, MAR drives ADDR, the MDR path drives DIN, and DOUT feeds the MDR/IR input muxes.

Parameters:
- DEPTH, 256, number of bytes in the array (power of 2).
- ADDR_W, 32, address port width.
- DATA_W, 32, data port width; fixed at 32 in this generation, must be a multiple of 8.
- LATENCY, 2, wait-state cycles spent in BUSY before the access completes (0..15).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  reset, asynchronous and active-high.
- MOV  in  1  memory operation valid, held high until MOC is seen.
- RW  in  1  1 = read, 0 = write.
- TYPE  in  2  size: 00 byte, 01 halfword, 10 word, 11 reserved.
- SGN  in  1  for reads: 1 = sign-extend, 0 = zero-extend byte/halfword.
- ADDR  in  ADDR_W  byte address.
- DIN  in  DATA_W  write data; the byte/halfword is taken from the low bits.
- DOUT  out  DATA_W  read data, registered.
- MOC  out  1  memory operation complete.
- ERR  out  1  qualifies MOC: the operation was rejected.

Behaviour:
- Storage: byte array named mem[0:DEPTH-1], big-endian.
  - Word at A = {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
  - Halfword at A = {mem[A], mem[A+1]}.
  - The bench preloads mem hierarchically. CLR never clears mem.
- Reset (CLR=1, asynchronous): state=IDLE, MOC=0, ERR=0, DOUT=0, wait counter=0. Reset during BUSY aborts the operation, and no memory write occurs.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On an edge with MOV=1, latch ADDR, RW, TYPE, SGN and DIN.
  - Check the request. It is an error if any of the following holds:
    - TYPE=11;
    - halfword with ADDR[0]≠0;
    - word with ADDR[1:0]≠0;
    - ADDR+size-1 ≥ DEPTH.
  - On error: go to DONE with ERR=1, MOC=1 on the same edge, and no memory access. DOUT is unchanged.
  - Otherwise: load counter=LATENCY and go to BUSY.
- BUSY:
  - Decrement the counter each edge.
  - On the edge where counter==0, perform the access and go to DONE with MOC=1, ERR=0.
  - Read: DOUT is loaded with the extended value on that same edge.
  - Write: only the addressed bytes are updated on that edge.
  - MOV dropping during BUSY is a protocol violation. The operation still completes.
- Timing: MOC rises LATENCY+1 edges after the edge that sampled MOV in IDLE. The LATENCY=0 case gives MOC one edge after capture.
- DONE:
  - MOC and ERR hold, and DOUT holds.
  - On the first edge with MOV=0, go to IDLE and clear MOC and ERR. DOUT keeps its value.
  - A new request is accepted no earlier than the edge after returning to IDLE, so back-to-back requests are separated by at least one MOV-low cycle.
- Extension:
  - Byte read: DOUT = {24{SGN & b[7]}, b}.
  - Halfword read: DOUT = {16{SGN & h[15]}, h}.
  - Word read ignores SGN.
- Address bits above log2(DEPTH) must be zero; otherwise the range error applies.

Decomposition:
- Shared package mem_pkg holds:
  - TYPE encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11.
  - State encodings: ST_IDLE, ST_BUSY, ST_DONE.
  - Size-in-bytes function.
- Sub-module: mem_load_extend, combinational. Inputs are the 4 raw bytes, TYPE and SGN; output is the 32-bit extended value. It is reused by the future data-cache fill path.
- FSM, wait counter, error check and array remain in mem_handshake_ram.

Test Plan:
1. Preload mem[4..7]=8C,01,02,03; LATENCY=2; word read ADDR=4 -> MOC high exactly 3 edges after MOV sampled, DOUT=32'h8C010203, ERR=0; MOV low -> MOC low next edge.
2. Byte read ADDR=4, SGN=1 -> DOUT=32'hFFFFFF8C; repeat with SGN=0 -> 32'h0000008C; halfword ADDR=6, SGN=1 -> 32'h00000203.
3. Halfword write DIN=32'h0000BEEF to ADDR=8 over mem[8..11]=11,22,33,44 -> mem[8..11]=BE,EF,33,44; word read ADDR=8 -> 32'hBEEF3344.
4. Word read ADDR=6 (misaligned), TYPE=11, and word ADDR=254 with DEPTH=256 -> each gives MOC=1 and ERR=1 one edge after capture, memory unchanged, DOUT unchanged.
5. Word write ADDR=0 DIN=32'hDEADBEEF, assert CLR asynchronously mid-BUSY -> MOC=0 and state IDLE immediately, mem[0..3] unchanged; a subsequent request completes normally.
6. LATENCY=0 build: word read -> MOC one edge after capture; MOV held high across DONE -> no second access until MOV drops and rises again.
